// File: rtl/wb_regfile.sv
// Write-back register file: 32x32 storage with write-back select, commit counter
// and an optional same-cycle write-to-read bypass on both read ports.
module wb_regfile #(
  parameter int BYPASS = 1
) (
  input  logic        clk_RF,
  input  logic        rst_RF,
  input  logic [31:0] data_RF_IN,
  input  logic [31:0] resALU_RF_IN,
  input  logic [4:0]  waddr_RF_IN,
  input  logic        RegWrite_RF_IN,
  input  logic        MemtoReg_RF_IN,
  input  logic [4:0]  raddr1_RF,
  input  logic [4:0]  raddr2_RF,
  output logic [31:0] rdata1_RF,
  output logic [31:0] rdata2_RF,
  output logic [31:0] wbData_RF,
  output logic [31:0] wbCount_RF
);

  logic [31:0] regs [32];
  logic        commit;
  logic        byp1;
  logic        byp2;

  assign wbData_RF = MemtoReg_RF_IN ? data_RF_IN : resALU_RF_IN;

  // Strict equality keeps an X/Z on the write controls from being read as a commit.
  assign commit = (RegWrite_RF_IN === 1'b1) && (waddr_RF_IN != 5'd0) &&
                  (waddr_RF_IN !== 5'bx) && (rst_RF == 1'b0);

  assign byp1 = (BYPASS == 1) && commit && (raddr1_RF == waddr_RF_IN);
  assign byp2 = (BYPASS == 1) && commit && (raddr2_RF == waddr_RF_IN);

  always_ff @(posedge clk_RF) begin
    if (rst_RF) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      wbCount_RF <= '0;
    end else if (commit) begin
      regs[waddr_RF_IN] <= wbData_RF;
      wbCount_RF        <= wbCount_RF + 32'd1;
    end
  end

  always_comb begin
    rdata1_RF = regs[raddr1_RF];
    if (raddr1_RF == 5'd0) begin
      rdata1_RF = '0;
    end else if (byp1) begin
      rdata1_RF = wbData_RF;
    end
  end

  always_comb begin
    rdata2_RF = regs[raddr2_RF];
    if (raddr2_RF == 5'd0) begin
      rdata2_RF = '0;
    end else if (byp2) begin
      rdata2_RF = wbData_RF;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one instance with bypass, one without,
// driven from the same write-back and read inputs.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [31:0] res_alu;
  logic [4:0]  waddr;
  logic        reg_write;
  logic        mem_to_reg;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;

  logic [31:0] rd1_b, rd2_b, wbd_b, cnt_b;
  logic [31:0] rd1_n, rd2_n, wbd_n, cnt_n;

  int checks = 0;
  int errors = 0;

  wb_regfile #(.BYPASS(1)) dut (
    .clk_RF(clk), .rst_RF(rst), .data_RF_IN(data_in), .resALU_RF_IN(res_alu),
    .waddr_RF_IN(waddr), .RegWrite_RF_IN(reg_write), .MemtoReg_RF_IN(mem_to_reg),
    .raddr1_RF(raddr1), .raddr2_RF(raddr2), .rdata1_RF(rd1_b), .rdata2_RF(rd2_b),
    .wbData_RF(wbd_b), .wbCount_RF(cnt_b)
  );

  wb_regfile #(.BYPASS(0)) dut_nb (
    .clk_RF(clk), .rst_RF(rst), .data_RF_IN(data_in), .resALU_RF_IN(res_alu),
    .waddr_RF_IN(waddr), .RegWrite_RF_IN(reg_write), .MemtoReg_RF_IN(mem_to_reg),
    .raddr1_RF(raddr1), .raddr2_RF(raddr2), .rdata1_RF(rd1_n), .rdata2_RF(rd2_n),
    .wbData_RF(wbd_n), .wbCount_RF(cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; data_in = '0; res_alu = '0; waddr = '0;
    reg_write = 1'b0; mem_to_reg = 1'b0; raddr1 = '0; raddr2 = '0;

    // reset, then sweep all addresses
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = a[4:0];
      #1;
      check($sformatf("rst_sweep_b[%0d]", a), rd1_b, 32'h0);
      check($sformatf("rst_sweep_n[%0d]", a), rd1_n, 32'h0);
    end
    check("rst_cnt", cnt_b, 32'h0);

    // ALU select into r5
    reg_write = 1'b1; mem_to_reg = 1'b0; res_alu = 32'h0000_1234;
    data_in = 32'hDEAD_BEEF; waddr = 5'd5;
    #1;
    check("wbdata_alu", wbd_b, 32'h0000_1234);
    tick();
    reg_write = 1'b0; raddr1 = 5'd5;
    #1;
    check("r5_alu", rd1_b, 32'h0000_1234);
    check("cnt_1", cnt_b, 32'd1);

    // memory select into r6
    reg_write = 1'b1; mem_to_reg = 1'b1; waddr = 5'd6;
    #1;
    check("wbdata_mem", wbd_b, 32'hDEAD_BEEF);
    tick();
    reg_write = 1'b0; raddr1 = 5'd6;
    #1;
    check("r6_mem", rd1_n, 32'hDEAD_BEEF);
    check("cnt_2", cnt_b, 32'd2);

    // write to $zero is dropped, including by the bypass
    reg_write = 1'b1; mem_to_reg = 1'b0; res_alu = 32'hFFFF_FFFF; waddr = 5'd0;
    raddr1 = 5'd0;
    #1;
    check("r0_byp", rd1_b, 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("r0_after", rd1_b, 32'h0);
    check("cnt_r0", cnt_b, 32'd2);

    // same-cycle bypass on both ports vs. no bypass
    reg_write = 1'b1; res_alu = 32'hA5A5_0001; waddr = 5'd9;
    raddr1 = 5'd9; raddr2 = 5'd9;
    #1;
    check("byp_rd1", rd1_b, 32'hA5A5_0001);
    check("byp_rd2", rd2_b, 32'hA5A5_0001);
    check("nobyp_rd1_pre", rd1_n, 32'h0);
    check("nobyp_rd2_pre", rd2_n, 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("nobyp_rd1_post", rd1_n, 32'hA5A5_0001);
    check("nobyp_rd2_post", rd2_n, 32'hA5A5_0001);
    check("cnt_3", cnt_n, 32'd3);

    // ports bypass independently
    reg_write = 1'b1; res_alu = 32'h0000_0BAD; waddr = 5'd9;
    raddr1 = 5'd9; raddr2 = 5'd5;
    #1;
    check("indep_rd1", rd1_b, 32'h0000_0BAD);
    check("indep_rd2", rd2_b, 32'h0000_1234);
    tick();
    reg_write = 1'b0;
    #1;
    check("cnt_4", cnt_b, 32'd4);

    // reset beats a simultaneous write; bypass off during reset
    rst = 1'b1; reg_write = 1'b1; res_alu = 32'h0000_0077; waddr = 5'd3;
    raddr1 = 5'd3; raddr2 = 5'd9;
    #1;
    check("rst_nobyp_rd1", rd1_b, 32'h0);
    check("rst_stored_rd2", rd2_b, 32'h0000_0BAD);
    tick();
    check("rst_r3", rd1_b, 32'h0);
    check("rst_r9", rd2_b, 32'h0);
    check("rst_cnt_b", cnt_b, 32'h0);
    check("rst_cnt_n", cnt_n, 32'h0);

    // first edge after reset commits
    rst = 1'b0;
    tick();
    reg_write = 1'b0;
    #1;
    check("first_commit_r3", rd1_n, 32'h0000_0077);
    check("first_commit_cnt", cnt_b, 32'd1);

    // counter wrap from a forced start value
    force dut.wbCount_RF = 32'hFFFF_FFFE;
    #1;
    release dut.wbCount_RF;
    #1;
    check("cnt_forced", cnt_b, 32'hFFFF_FFFE);
    reg_write = 1'b1; waddr = 5'd10; raddr1 = 5'd10;
    res_alu = 32'd1;
    tick();
    check("wrap_ffffffff", cnt_b, 32'hFFFF_FFFF);
    res_alu = 32'd2;
    tick();
    check("wrap_0", cnt_b, 32'h0000_0000);
    res_alu = 32'd3;
    tick();
    check("wrap_1", cnt_b, 32'h0000_0001);
    reg_write = 1'b0;
    #1;
    check("r10_last", rd1_b, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
